acx_cnt_window_ctrl: RTL and testbench

//  Sequencer for one AXI-slave counter register. Drives the counter's control word and count enable to take

---
 rtl/acx_cnt_window_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_acx_cnt_window_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/acx_cnt_window_ctrl.sv
// Gated-measurement sequencer for one counter register: clear, count for N cycles, capture, optional repeat.
// Optional completed-window counter on o_run_count is enabled by defining ACX_CNT_WIN_RUN_COUNT_EN.
module acx_cnt_window_ctrl #(
  parameter int TGT_DATA_WIDTH = 32,
  parameter int WINDOW_WIDTH   = 32,
  parameter int CLR_CYCLES     = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_start,
  input  logic                      i_stop,
  input  logic [WINDOW_WIDTH-1:0]   i_window_len,
  input  logic                      i_down,
  input  logic                      i_repeat,
  input  logic                      i_event,
  input  logic [TGT_DATA_WIDTH-1:0] i_cnt_value,
  output logic [TGT_DATA_WIDTH-1:0] o_cnt_control,
  output logic                      o_cnt_en,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_aborted,
  output logic [TGT_DATA_WIDTH-1:0] o_result,
  output logic [15:0]               o_run_count
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CLEAR   = 2'd1;
  localparam logic [1:0] ST_RUN     = 2'd2;
  localparam logic [1:0] ST_CAPTURE = 2'd3;

  localparam logic [3:0]              CLR_LOAD = 4'(CLR_CYCLES - 1);
  localparam logic [WINDOW_WIDTH-1:0] LEN_ONE  = WINDOW_WIDTH'(1);
  localparam logic [WINDOW_WIDTH-1:0] LEN_ZERO = {WINDOW_WIDTH{1'b0}};

  logic [1:0]                state_q, state_d;
  logic [WINDOW_WIDTH-1:0]   len_q, len_d;
  logic                      down_q, down_d;
  logic [3:0]                clr_timer_q, clr_timer_d;
  logic [WINDOW_WIDTH-1:0]   win_timer_q, win_timer_d;
  logic [TGT_DATA_WIDTH-1:0] control_q, control_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      aborted_q, aborted_d;
  logic [TGT_DATA_WIDTH-1:0] result_q, result_d;
  logic                      start_acc_s;

  // Next-state, operand latching and capture decisions
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    down_d      = down_q;
    clr_timer_d = clr_timer_q;
    win_timer_d = win_timer_q;
    done_d      = 1'b0;
    aborted_d   = 1'b0;
    result_d    = result_q;
    start_acc_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start && !i_stop) begin
          state_d     = ST_CLEAR;
          len_d       = (i_window_len == LEN_ZERO) ? LEN_ONE : i_window_len;
          down_d      = i_down;
          clr_timer_d = CLR_LOAD;
          start_acc_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (i_stop) begin
          state_d   = ST_IDLE;
          aborted_d = 1'b1;
        end else if (clr_timer_q == 4'd0) begin
          state_d     = ST_RUN;
          win_timer_d = len_q - LEN_ONE;
        end else begin
          clr_timer_d = clr_timer_q - 4'd1;
        end
      end
      ST_RUN: begin
        if (i_stop) begin
          state_d   = ST_IDLE;
          aborted_d = 1'b1;
        end else if (win_timer_q == LEN_ZERO) begin
          state_d = ST_CAPTURE;
        end else begin
          win_timer_d = win_timer_q - LEN_ONE;
        end
      end
      ST_CAPTURE: begin
        // Stop outranks both capture and repeat
        if (i_stop) begin
          state_d   = ST_IDLE;
          aborted_d = 1'b1;
        end else begin
          result_d = i_cnt_value;
          done_d   = 1'b1;
          if (i_repeat) begin
            state_d     = ST_CLEAR;
            len_d       = (i_window_len == LEN_ZERO) ? LEN_ONE : i_window_len;
            down_d      = i_down;
            clr_timer_d = CLR_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control word decoded from the upcoming state so it is registered alongside it
  always_comb begin
    control_d = {TGT_DATA_WIDTH{1'b0}};
    busy_d    = (state_d != ST_IDLE);
    case (state_d)
      ST_CLEAR: begin
        control_d[0] = 1'b1;
        control_d[2] = down_d;
      end
      ST_RUN: begin
        control_d[1] = 1'b1;
        control_d[2] = down_d;
      end
      default: begin
        control_d = {TGT_DATA_WIDTH{1'b0}};
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      len_q       <= LEN_ZERO;
      down_q      <= 1'b0;
      clr_timer_q <= 4'd0;
      win_timer_q <= LEN_ZERO;
      control_q   <= {TGT_DATA_WIDTH{1'b0}};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      result_q    <= {TGT_DATA_WIDTH{1'b0}};
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      down_q      <= down_d;
      clr_timer_q <= clr_timer_d;
      win_timer_q <= win_timer_d;
      control_q   <= control_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
      result_q    <= result_d;
    end
  end

`ifdef ACX_CNT_WIN_RUN_COUNT_EN
  logic [15:0] run_count_q;

  // Completed-window counter, saturating, restarted by each accepted start
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      run_count_q <= 16'h0000;
    end else if (start_acc_s) begin
      run_count_q <= 16'h0000;
    end else if (done_d && (run_count_q != 16'hFFFF)) begin
      run_count_q <= run_count_q + 16'd1;
    end else begin
      run_count_q <= run_count_q;
    end
  end

  assign o_run_count = run_count_q;
`else
  assign o_run_count = 16'h0000;
`endif

  assign o_cnt_control = control_q;
  assign o_cnt_en      = (state_q == ST_RUN) & i_event;
  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_aborted     = aborted_q;
  assign o_result      = result_q;

endmodule

// File: tb/tb_acx_cnt_window_ctrl.sv
// Directed bench for acx_cnt_window_ctrl with a behavioural counter register closing the loop.
module tb_acx_cnt_window_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic        i_stop;
  logic [31:0] i_window_len;
  logic        i_down;
  logic        i_repeat;
  logic        i_event;
  logic [31:0] i_cnt_value;
  logic [31:0] o_cnt_control;
  logic        o_cnt_en;
  logic        o_busy;
  logic        o_done;
  logic        o_aborted;
  logic [31:0] o_result;
  logic [15:0] o_run_count;

  int n_checks = 0;
  int n_fail   = 0;

  acx_cnt_window_ctrl #(
    .TGT_DATA_WIDTH(32),
    .WINDOW_WIDTH  (32),
    .CLR_CYCLES    (2)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_start      (i_start),
    .i_stop       (i_stop),
    .i_window_len (i_window_len),
    .i_down       (i_down),
    .i_repeat     (i_repeat),
    .i_event      (i_event),
    .i_cnt_value  (i_cnt_value),
    .o_cnt_control(o_cnt_control),
    .o_cnt_en     (o_cnt_en),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_aborted    (o_aborted),
    .o_result     (o_result),
    .o_run_count  (o_run_count)
  );

  always #5 i_clk = ~i_clk;

  // Counter register: clear wins, otherwise count when run and enabled
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      i_cnt_value <= 32'd0;
    end else if (o_cnt_control[0]) begin
      i_cnt_value <= 32'd0;
    end else if (o_cnt_control[1] && o_cnt_en) begin
      i_cnt_value <= o_cnt_control[2] ? i_cnt_value - 32'd1 : i_cnt_value + 32'd1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Start a window at cycle 0 and run to o_done; optional i_start pulse at start_cyc
  task automatic run_window(input logic [31:0] len, input logic down, input logic toggle,
                            input int start_cyc, output int done_cyc,
                            output logic [31:0] clr_ctl, output logic [31:0] run_ctl);
    int cyc;
    cyc          = 0;
    done_cyc     = -1;
    clr_ctl      = 32'hDEAD_BEEF;
    run_ctl      = 32'hDEAD_BEEF;
    i_window_len = len;
    i_down       = down;
    i_start      = 1'b1;
    i_event      = 1'b1;
    while (cyc < 200) begin
      step();
      cyc++;
      i_start = (cyc == start_cyc) ? 1'b1 : 1'b0;
      i_event = toggle ? cyc[0] : 1'b1;
      if (cyc == 1) clr_ctl = o_cnt_control;
      if (cyc == 3) run_ctl = o_cnt_control;
      if (o_done) begin
        done_cyc = cyc;
        break;
      end
    end
    i_start = 1'b0;
  endtask

  logic [15:0] rc1;
  int          dc;
  logic [31:0] cc;
  logic [31:0] rcl;
  int          dn;

  initial begin
`ifdef ACX_CNT_WIN_RUN_COUNT_EN
    rc1 = 16'd1;
`else
    rc1 = 16'd0;
`endif
    i_rst = 1'b1; i_start = 1'b0; i_stop = 1'b0; i_window_len = 32'd0;
    i_down = 1'b0; i_repeat = 1'b0; i_event = 1'b0;
    step(); step(); step();
    check_eq("rst_busy", {31'd0, o_busy}, 32'd0);
    check_eq("rst_ctl", o_cnt_control, 32'd0);
    check_eq("rst_result", o_result, 32'd0);
    check_eq("rst_done", {30'd0, o_done, o_aborted}, 32'd0);
    check_eq("rst_runcnt", {16'd0, o_run_count}, 32'd0);
    i_rst = 1'b0;
    step();

    // 1: len=10 up, constant events
    run_window(32'd10, 1'b0, 1'b0, 0, dc, cc, rcl);
    check_eq("t1_done_cyc", dc, 32'd14);
    check_eq("t1_result", o_result, 32'd10);
    check_eq("t1_busy", {31'd0, o_busy}, 32'd0);
    check_eq("t1_clr_ctl", cc, 32'h1);
    check_eq("t1_run_ctl", rcl, 32'h2);
    check_eq("t1_runcnt", {16'd0, o_run_count}, {16'd0, rc1});
    step(); step();

    // 2: len=8 with alternating events
    run_window(32'd8, 1'b0, 1'b1, 0, dc, cc, rcl);
    check_eq("t2_done_cyc", dc, 32'd12);
    check_eq("t2_result", o_result, 32'd4);
    step(); step();

    // 3: len=3 down, wraps below zero
    run_window(32'd3, 1'b1, 1'b0, 0, dc, cc, rcl);
    check_eq("t3_done_cyc", dc, 32'd7);
    check_eq("t3_result", o_result, 32'hFFFF_FFFD);
    check_eq("t3_clr_ctl", cc, 32'h5);
    check_eq("t3_run_ctl", rcl, 32'h6);
    step(); step();

    // 4: len=100, stop during the fifth RUN cycle (cycle 7)
    i_window_len = 32'd100; i_down = 1'b0; i_start = 1'b1; i_event = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      step();
      i_start = 1'b0;
      check_eq("t4_no_done", {31'd0, o_done}, 32'd0);
    end
    i_stop = 1'b1;
    step();
    i_stop = 1'b0;
    check_eq("t4_aborted", {31'd0, o_aborted}, 32'd1);
    check_eq("t4_done", {31'd0, o_done}, 32'd0);
    check_eq("t4_busy", {31'd0, o_busy}, 32'd0);
    check_eq("t4_ctl", o_cnt_control, 32'd0);
    check_eq("t4_result", o_result, 32'hFFFF_FFFD);
    step();
    check_eq("t4_abort_pulse", {31'd0, o_aborted}, 32'd0);
    check_eq("t4_done_after", {31'd0, o_done}, 32'd0);
    step();

    // 5: len=4 auto-repeat; drop repeat after third done so the fourth window ends
    i_window_len = 32'd4; i_down = 1'b0; i_repeat = 1'b1; i_start = 1'b1; i_event = 1'b1;
    dn = 0;
    for (int c = 1; c <= 40; c++) begin
      step();
      i_start = 1'b0;
      if (o_done) begin
        dn++;
        check_eq("t5_done_cyc", c, 1 + 7 * dn);
        check_eq("t5_result", o_result, 32'd4);
        check_eq("t5_runcnt", {16'd0, o_run_count}, {16'd0, rc1 * 16'(dn)});
        if (dn == 3) i_repeat = 1'b0;
      end
    end
    check_eq("t5_num_done", dn, 32'd4);
    check_eq("t5_busy_end", {31'd0, o_busy}, 32'd0);

    // 6: len=0 acts as len=1; start during RUN is ignored
    run_window(32'd0, 1'b0, 1'b0, 0, dc, cc, rcl);
    check_eq("t6_len0_cyc", dc, 32'd5);
    check_eq("t6_len0_result", o_result, 32'd1);
    step(); step();
    run_window(32'd5, 1'b0, 1'b0, 4, dc, cc, rcl);
    check_eq("t6_ign_cyc", dc, 32'd9);
    check_eq("t6_ign_result", o_result, 32'd5);
    step();
    check_eq("t6_ign_busy", {31'd0, o_busy}, 32'd0);

    // start together with stop in IDLE is ignored
    i_start = 1'b1; i_stop = 1'b1;
    step();
    i_start = 1'b0; i_stop = 1'b0;
    check_eq("ss_busy", {31'd0, o_busy}, 32'd0);
    step();
    check_eq("ss_aborted", {31'd0, o_aborted}, 32'd0);

    // reset mid-window
    i_window_len = 32'd50; i_start = 1'b1;
    step(); i_start = 1'b0;
    step(); step(); step(); step();
    check_eq("mr_busy_pre", {31'd0, o_busy}, 32'd1);
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    check_eq("mr_busy", {31'd0, o_busy}, 32'd0);
    check_eq("mr_ctl", o_cnt_control, 32'd0);
    check_eq("mr_result", o_result, 32'd0);
    step();
    check_eq("mr_pulses", {30'd0, o_done, o_aborted}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
